// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-master APB arbiter.
// Provides the FSM state enum, the master id type and the bus widths.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef logic master_id_t;

    localparam master_id_t MASTER0 = 1'b0;
    localparam master_id_t MASTER1 = 1'b1;

    localparam int APB_AW = 16;
    localparam int APB_DW = 16;

    // A timeout of 0 still needs a 1-bit counter to keep the vector legal.
    function automatic int cnt_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
// Ports: req0_i/req1_i requests, last_i previous winner; winner_o, valid_o.
module rr_arb2
    import apb_arb_pkg::*;
(
    input  logic       req0_i,
    input  logic       req1_i,
    input  master_id_t last_i,
    output master_id_t winner_o,
    output logic       valid_o
);

    always_comb begin
        valid_o  = req0_i | req1_i;
        winner_o = MASTER0;
        if (req0_i && req1_i) begin
            // Contention: whoever did not win last time goes first.
            winner_o = master_id_t'(~last_i);
        end else if (req1_i) begin
            winner_o = MASTER1;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB bus between master 0 (CPU) and master 1 (DMA/boot),
// round-robin arbitration, SETUP/ACCESS sequencing and slave timeout.
// Ports: clk, reset (sync, active-high); req/addr/write/wdata per master;
// gnt/done per master, rdata, err; APB paddr/pwrite/psel/penable/pwdata,
// prdata, pready. All outputs are registered.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int AW      = APB_AW,
    parameter int DW      = APB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic          write0,
    input  logic          write1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic [AW-1:0] paddr,
    output logic          pwrite,
    output logic          psel,
    output logic          penable,
    output logic [DW-1:0] pwdata,
    input  logic [DW-1:0] prdata,
    input  logic          pready
);

    localparam int            CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    state_t        state_q, state_d;
    master_id_t    owner_q, owner_d;
    master_id_t    last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic          pwrite_q, pwrite_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;

    master_id_t    arb_win;
    logic          arb_valid;

    rr_arb2 u_rr_arb2 (
        .req0_i   (req0),
        .req1_i   (req1),
        .last_i   (last_q),
        .winner_o (arb_win),
        .valid_o  (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d  = SETUP;
                    owner_d  = arb_win;
                    last_d   = arb_win;
                    paddr_d  = arb_win ? addr1 : addr0;
                    pwrite_d = arb_win ? write1 : write0;
                    pwdata_d = arb_win ? wdata1 : wdata0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // pready has priority over an expiring timeout.
                if (pready) begin
                    if (!pwrite_q) begin
                        rdata_d = prdata;
                    end
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus-facing flags are derived from the next state so that they
        // appear on the same edge the state changes.
        psel_d    = (state_d == SETUP) || (state_d == ACCESS);
        penable_d = (state_d == ACCESS);
        gnt0_d    = (state_d != IDLE) && (owner_d == MASTER0);
        gnt1_d    = (state_d != IDLE) && (owner_d == MASTER1);
        done0_d   = (state_d == DONE) && (owner_d == MASTER0);
        done1_d   = (state_d == DONE) && (owner_d == MASTER1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= MASTER0;
            last_q    <= MASTER1;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign paddr   = paddr_q;
    assign pwrite  = pwrite_q;
    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: transaction-level model compared every
// cycle, plus directed transfers with hand-computed expectations.
module tb_apb_master_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, write0, write1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, err;
    logic [15:0] rdata, paddr, pwdata, prdata;
    logic        pwrite, psel, penable, pready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apb_master_arbiter #(.TIMEOUT(TO), .AW(16), .DW(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .write0(write0), .write1(write1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1),
        .rdata(rdata), .err(err),
        .paddr(paddr), .pwrite(pwrite),
        .psel(psel), .penable(penable),
        .pwdata(pwdata), .prdata(prdata),
        .pready(pready)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction-level model: a transfer is granted, spends one SETUP
    // cycle, then some number of ACCESS cycles, then one completion cycle.
    logic        e_psel, e_pen, e_g0, e_g1, e_d0, e_d1, e_err, e_pwrite;
    logic [15:0] e_paddr, e_pwdata, e_rdata;
    bit          m_busy, m_fin, m_owner, m_last;
    int          m_acc;

    always @(posedge clk) begin
        e_d0 = 1'b0;
        e_d1 = 1'b0;
        if (reset) begin
            e_psel = 0; e_pen = 0; e_g0 = 0; e_g1 = 0;
            e_err = 0; e_pwrite = 0;
            e_paddr = 0; e_pwdata = 0; e_rdata = 0;
            m_busy = 0; m_fin = 0; m_last = 1; m_acc = 0;
        end else if (!m_busy) begin
            if (req0 || req1) begin
                m_owner  = (req0 && req1) ? !m_last : req1;
                m_last   = m_owner;
                m_busy   = 1; m_fin = 0; m_acc = -1;
                e_paddr  = m_owner ? addr1 : addr0;
                e_pwrite = m_owner ? write1 : write0;
                e_pwdata = m_owner ? wdata1 : wdata0;
                e_psel   = 1; e_pen = 0;
                e_g0     = !m_owner; e_g1 = m_owner;
            end
        end else if (m_fin) begin
            m_busy = 0; e_g0 = 0; e_g1 = 0;
        end else if (m_acc < 0) begin
            m_acc = 0; e_pen = 1;
        end else if (pready || (m_acc + 1 == TO)) begin
            m_fin = 1; e_psel = 0; e_pen = 0;
            e_err = !pready;
            if (pready && !e_pwrite) e_rdata = prdata;
            e_d0 = !m_owner; e_d1 = m_owner;
        end else begin
            m_acc++;
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            #1;
            chk("psel", psel, e_psel);
            chk("penable", penable, e_pen);
            chk("gnt0", gnt0, e_g0);
            chk("gnt1", gnt1, e_g1);
            chk("done0", done0, e_d0);
            chk("done1", done1, e_d1);
            chk("err", err, e_err);
            chk("rdata", rdata, e_rdata);
            chk("paddr", paddr, e_paddr);
            chk("pwrite", pwrite, e_pwrite);
            chk("pwdata", pwdata, e_pwdata);
            @(posedge clk);
        end
    end

    // One transfer from an idle bus; delay = low-pready ACCESS cycles
    // before pready rises, -1 = never rises.
    task automatic run_txn(input string nm, input int m,
                           input logic [15:0] a, input logic wr,
                           input logic [15:0] wd, input logic [15:0] pd,
                           input int delay, input int exp_n,
                           input logic exp_err, input logic [15:0] exp_rd);
        int n, sel, acc;
        bit other, got;
        repeat (2) @(negedge clk);
        chk({nm, "_idle"}, {psel, gnt0, gnt1}, 3'b000);
        if (m == 0) begin
            req0 = 1; addr0 = a; write0 = wr; wdata0 = wd;
        end else begin
            req1 = 1; addr1 = a; write1 = wr; wdata1 = wd;
        end
        prdata = pd;
        pready = (delay == 0);
        n = 0; sel = 0; acc = 0; other = 0; got = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #3;
            n++;
            if (psel) sel++;
            if (penable) begin
                acc++;
                chk({nm, "_paddr"}, paddr, a);
                chk({nm, "_pwdata"}, pwdata, wd);
                pready = (delay >= 0) && (acc >= delay + 1);
            end
            if ((m == 0) ? gnt1 : gnt0) other = 1;
            if ((m == 0) ? done0 : done1) begin
                got = 1;
                break;
            end
        end
        req0 = 0; req1 = 0; pready = 0;
        chk({nm, "_done_seen"}, got, 1'b1);
        chk({nm, "_latency"}, n, exp_n);
        chk({nm, "_psel_cycles"}, sel, exp_n - 1);
        chk({nm, "_access_cycles"}, acc, exp_n - 2);
        chk({nm, "_err"}, err, exp_err);
        chk({nm, "_rdata"}, rdata, exp_rd);
        chk({nm, "_other_gnt"}, other, 1'b0);
    endtask

    initial begin
        int   ng, nd;
        bit   order [4];
        bit   raise0, raise1, first, seen;

        reset = 1; req0 = 0; req1 = 0; write0 = 0; write1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        prdata = 0; pready = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {psel, penable, gnt0, gnt1, done0, done1, err},
            7'd0);
        chk("reset_buses", {paddr, pwdata, rdata}, 48'd0);
        reset = 0;

        run_txn("t1_read", 0, 16'h4010, 0, 16'h0000, 16'hBEEF,
                0, 3, 0, 16'hBEEF);
        run_txn("t3_write", 1, 16'h8002, 1, 16'h00A5, 16'h1234,
                3, 6, 0, 16'hBEEF);
        run_txn("t4_timeout", 0, 16'h0100, 0, 16'h0000, 16'h5555,
                -1, TO + 2, 1, 16'hBEEF);
        run_txn("t4_after", 1, 16'hC000, 0, 16'h0000, 16'h7777,
                1, 4, 0, 16'h7777);
        run_txn("t6_edge", 0, 16'h4002, 0, 16'h0000, 16'h9A9A,
                TO - 1, TO + 2, 0, 16'h9A9A);

        // Round-robin under continuous contention.
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
        addr0 = 16'h1000; addr1 = 16'h2000; write0 = 0; write1 = 0;
        prdata = 16'h0C0C; pready = 1; req0 = 1; req1 = 1;
        ng = 0; nd = 0; raise0 = 0; raise1 = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #3;
            if (psel && !penable && ng < 4) begin
                order[ng] = gnt1;
                ng++;
            end
            if (raise0) begin req0 = 1; raise0 = 0; end
            if (raise1) begin req1 = 1; raise1 = 0; end
            if (done0) begin req0 = 0; nd++; if (nd < 3) raise0 = 1; end
            if (done1) begin req1 = 0; nd++; if (nd < 3) raise1 = 1; end
            if (nd == 4) break;
        end
        req0 = 0; req1 = 0; pready = 0;
        chk("t2_dones", nd, 4);
        chk("t2_order", {order[0], order[1], order[2], order[3]}, 4'b0101);

        // Reset during ACCESS, then contention must favour master 0.
        repeat (2) @(negedge clk);
        req0 = 1; addr0 = 16'h4444; write0 = 1; wdata0 = 16'hAAAA;
        pready = 0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #3;
            if (penable) begin seen = 1; break; end
        end
        chk("t5_in_access", seen, 1'b1);
        @(negedge clk); reset = 1; req0 = 0;
        @(posedge clk);
        #3;
        chk("t5_reset_ctl", {psel, penable, gnt0, gnt1, done0, done1},
            6'd0);
        chk("t5_reset_bus", {paddr, pwdata}, 32'd0);
        @(negedge clk); reset = 0; req0 = 1; req1 = 1; pready = 1;
        addr0 = 16'h0008; addr1 = 16'h000C; write0 = 0; write1 = 0;
        prdata = 16'h3C3C;
        seen = 0; first = 1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #3;
            if (psel) begin seen = 1; first = gnt1; break; end
        end
        // Dropping both requests mid-transfer must not cancel it.
        req0 = 0; req1 = 0;
        chk("t5_granted", seen, 1'b1);
        chk("t5_first_owner", first, 1'b0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #3;
            if (done0) begin seen = 1; break; end
        end
        chk("t5_done_after_drop", seen, 1'b1);
        chk("t5_rdata", rdata, 16'h3C3C);
        repeat (4) @(negedge clk);
        chk("t5_idle_end", {psel, gnt0, gnt1}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
